// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: default palette,
// the transparent index and a helper that slices the flattened index bus.
package compositor_pkg;

  localparam int MAX_BUS_W   = 256;
  localparam int MAX_INDEX_W = 8;
  localparam int DEFAULT_PAL_N = 32;

  localparam int TRANSPARENT = 0;

  // Entry i sits at bits [i*24 +: 24]; entry 0 is listed last.
  localparam logic [DEFAULT_PAL_N-1:0][23:0] DEFAULT_PALETTE = {
    {16{24'h000000}},
    24'h787878, 24'h503000, 24'hA81000, 24'hFCE0A8,
    24'hD8B8F8, 24'h6888FC, 24'hB8F818, 24'hF8D878,
    24'h5888B8, 24'h00A800, 24'h0058F8, 24'hF87858,
    24'h980000, 24'hF8F8F8, 24'h000000, 24'h010101
  };

  function automatic logic [MAX_INDEX_W-1:0] layer_slice(
    input logic [MAX_BUS_W-1:0] vec,
    input int unsigned          i,
    input int unsigned          w
  );
    logic [MAX_BUS_W-1:0]   shifted;
    logic [MAX_INDEX_W-1:0] r;
    shifted = vec >> (i * w);
    r = shifted[MAX_INDEX_W-1:0];
    for (int b = 0; b < MAX_INDEX_W; b++) begin
      if (b >= int'(w)) r[b] = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_compositor_flash_timer.sv
// Per-layer hit-flash frame counter; a load overrides a same-cycle decrement,
// and the count saturates at zero.
module flash_timer #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_active
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(FLASH_FRAMES);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_active = (r_count != '0);

endmodule

// File: rtl/layer_compositor.sv
// N-layer sprite compositor: priority pick, palette lookup, hit-flash and blanking.
// Two-stage pipeline, one pixel per clock, no backpressure.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int          LAYERS       = 6,
  parameter int          INDEX_W      = 5,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [23:0] FLASH_COLOR  = 24'hF8F8F8,
  localparam int         WIN_W        = $clog2(LAYERS + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        blank_n,
  input  logic                        frame_start,
  input  logic [LAYERS-1:0]           layer_hit,
  input  logic [LAYERS*INDEX_W-1:0]   layer_index,
  input  logic [LAYERS-1:0]           layer_en,
  input  logic [23:0]                 bkg_color,
  input  logic [LAYERS-1:0]           flash_req,
  input  logic                        pal_we,
  input  logic [INDEX_W-1:0]          pal_addr,
  input  logic [23:0]                 pal_data,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        VGA_BLANK_N,
  output logic [WIN_W-1:0]            winner
);

  localparam int PAL_N = 1 << INDEX_W;
  localparam logic [WIN_W-1:0] BKG_ID = WIN_W'(LAYERS);

  logic [INDEX_W-1:0] w_idx [LAYERS];
  logic [WIN_W-1:0]   w_win;
  logic [INDEX_W-1:0] w_win_idx;
  logic [LAYERS-1:0]  w_active;
  logic [23:0]        w_color;

  logic [WIN_W-1:0]   r1_win;
  logic [INDEX_W-1:0] r1_idx;
  logic [23:0]        r1_bkg;
  logic               r1_blank;

  logic [23:0]        r2_rgb;
  logic               r2_blank;
  logic [WIN_W-1:0]   r2_win;

  logic [23:0]        r_pal [PAL_N];
  logic               r_phase;

  // Scan from the lowest priority upward so the lowest-numbered opaque layer wins.
  always_comb begin
    w_win     = BKG_ID;
    w_win_idx = '0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      w_idx[i] = INDEX_W'(layer_slice(MAX_BUS_W'(layer_index), i, INDEX_W));
      if (layer_hit[i] && layer_en[i] && (w_idx[i] != INDEX_W'(TRANSPARENT))) begin
        w_win     = WIN_W'(i);
        w_win_idx = w_idx[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r1_win   <= BKG_ID;
      r1_idx   <= '0;
      r1_bkg   <= '0;
      r1_blank <= 1'b0;
    end else begin
      r1_win   <= w_win;
      r1_idx   <= w_win_idx;
      r1_bkg   <= bkg_color;
      r1_blank <= blank_n;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int e = 0; e < PAL_N; e++) begin
        r_pal[e] <= (e < DEFAULT_PAL_N) ? DEFAULT_PALETTE[e] : 24'h000000;
      end
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_phase <= 1'b0;
    else if (frame_start) r_phase <= ~r_phase;
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_flash
    flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
      .i_clk   (Clk),
      .i_rst   (Reset),
      .i_load  (flash_req[g]),
      .i_dec   (frame_start),
      .o_active(w_active[g])
    );
  end

  // Palette is read at the stage-2 edge, so a same-edge write is not yet visible.
  always_comb begin
    w_color = r_pal[r1_idx];
    if (r1_win == BKG_ID) begin
      w_color = r1_bkg;
    end else if (w_active[r1_win] && r_phase) begin
      w_color = FLASH_COLOR;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r2_rgb   <= '0;
      r2_blank <= 1'b0;
      r2_win   <= BKG_ID;
    end else begin
      r2_rgb   <= r1_blank ? w_color : 24'h000000;
      r2_blank <= r1_blank;
      r2_win   <= r1_win;
    end
  end

  assign VGA_R       = r2_rgb[23:16];
  assign VGA_G       = r2_rgb[15:8];
  assign VGA_B       = r2_rgb[7:0];
  assign VGA_BLANK_N = r2_blank;
  assign winner      = r2_win;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed-vector bench for layer_compositor (6 layers, 2-frame flash).
module tb_layer_compositor;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        blank_n;
  logic        frame_start;
  logic [5:0]  layer_hit;
  logic [29:0] layer_index;
  logic [5:0]  layer_en;
  logic [23:0] bkg_color;
  logic [5:0]  flash_req;
  logic        pal_we;
  logic [4:0]  pal_addr;
  logic [23:0] pal_data;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_BLANK_N;
  logic [2:0]  winner;

  int n_vec = 0;
  int n_bad = 0;

  layer_compositor #(
    .LAYERS(6), .INDEX_W(5), .FLASH_FRAMES(2), .FLASH_COLOR(24'hF8F8F8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .blank_n(blank_n), .frame_start(frame_start),
    .layer_hit(layer_hit), .layer_index(layer_index), .layer_en(layer_en),
    .bkg_color(bkg_color), .flash_req(flash_req), .pal_we(pal_we),
    .pal_addr(pal_addr), .pal_data(pal_data), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .VGA_BLANK_N(VGA_BLANK_N), .winner(winner)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  hit;
    logic [29:0] idx;
    logic [5:0]  en;
    logic [23:0] bkg;
    logic        blank;
    logic        fs;
    logic [5:0]  freq;
    logic [23:0] e_rgb;
    logic        e_blank;
    logic [2:0]  e_win;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [29:0] ix(int a0, int a1, int a2, int a3, int a4, int a5);
    return {5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic vec_t mk(logic [5:0] hit, logic [29:0] idx, logic [5:0] en,
                              logic [23:0] bkg, logic blank, logic fs, logic [5:0] freq,
                              logic [23:0] e_rgb, logic e_blank, logic [2:0] e_win);
    vec_t v;
    v.hit = hit; v.idx = idx; v.en = en; v.bkg = bkg; v.blank = blank;
    v.fs = fs; v.freq = freq; v.e_rgb = e_rgb; v.e_blank = e_blank; v.e_win = e_win;
    return v;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [23:0] rgb, input logic bl, input logic [2:0] w);
    check({nm, "_rgb"},   {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, rgb});
    check({nm, "_blank"}, {31'h0, VGA_BLANK_N}, {31'h0, bl});
    check({nm, "_win"},   {29'h0, winner}, {29'h0, w});
  endtask

  initial begin
    Reset = 1'b1; blank_n = 1'b0; frame_start = 1'b0; layer_hit = '0;
    layer_index = '0; layer_en = '1; bkg_color = '0; flash_req = '0;
    pal_we = 1'b0; pal_addr = '0; pal_data = '0;

    // Priority, transparency, enable, blanking.
    tbl.push_back(mk(6'b001010, ix(0,3,0,5,0,0), 6'h3F, 24'h0A0B0C, 1, 0, 0, 24'h980000, 1, 3'd1));
    tbl.push_back(mk(6'b000101, ix(0,0,2,0,0,0), 6'h3F, 24'h0A0B0C, 1, 0, 0, 24'hF8F8F8, 1, 3'd2));
    tbl.push_back(mk(6'b000101, ix(0,0,2,0,0,0), 6'h3B, 24'h0A0B0C, 1, 0, 0, 24'h0A0B0C, 1, 3'd6));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0A0B0C, 0, 0, 0, 24'h000000, 0, 3'd0));
    tbl.push_back(mk(6'b000000, ix(3,3,3,3,3,3), 6'h3F, 24'h102030, 1, 0, 0, 24'h102030, 1, 3'd6));
    tbl.push_back(mk(6'b110000, ix(0,0,0,0,7,1), 6'h3F, 24'h102030, 1, 0, 0, 24'h5888B8, 1, 3'd4));
    tbl.push_back(mk(6'b100000, ix(0,0,0,0,0,20), 6'h3F, 24'h102030, 1, 0, 0, 24'h000000, 1, 3'd5));
    tbl.push_back(mk(6'b111111, ix(0,2,3,3,3,3), 6'h3F, 24'h102030, 1, 0, 0, 24'hF8F8F8, 1, 3'd1));
    // Flash on layer 0 (idx 3 = 980000); phase starts at 0.
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 0, 6'b000001, 24'h980000, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'hF8F8F8, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'h980000, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'h980000, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'h980000, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'h980000, 1, 3'd0));
    // Reload coincident with frame_start: count 2 at phase 0, so next frame still flashes.
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000001, 24'h980000, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'hF8F8F8, 1, 3'd0));
    tbl.push_back(mk(6'b000001, ix(3,0,0,0,0,0), 6'h3F, 24'h0, 1, 1, 6'b000000, 24'h980000, 1, 3'd0));

    step(); step();
    check_out("reset", 24'h0, 1'b0, 3'd6);
    Reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      layer_hit = tbl[k].hit; layer_index = tbl[k].idx; layer_en = tbl[k].en;
      bkg_color = tbl[k].bkg; blank_n = tbl[k].blank;
      frame_start = tbl[k].fs; flash_req = tbl[k].freq;
      step();
      frame_start = 1'b0; flash_req = '0;
      step();
      check_out($sformatf("vec%0d", k), tbl[k].e_rgb, tbl[k].e_blank, tbl[k].e_win);
    end

    // Palette write landing on the same edge as a lookup of entry 7.
    layer_hit = 6'b010000; layer_index = ix(0,0,0,0,7,0); layer_en = '1; blank_n = 1'b1;
    step();
    pal_we = 1'b1; pal_addr = 5'd7; pal_data = 24'h123456;
    step();
    pal_we = 1'b0;
    check_out("pal_old", 24'h5888B8, 1'b1, 3'd4);
    step();
    check_out("pal_new", 24'h123456, 1'b1, 3'd4);

    // Reset mid-stream, then refill.
    step();
    Reset = 1'b1;
    step();
    check_out("rst_mid", 24'h0, 1'b0, 3'd6);
    Reset = 1'b0;
    step();
    check_out("rst_fill", 24'h0, 1'b0, 3'd6);
    step();
    check_out("rst_first", 24'h5888B8, 1'b1, 3'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
